hpram_clk_supervisor: RTL and testbench
=======================================

// Module: hpram_clk_supervisor
// PURPOSE
//  Consumer end of the HyperRAM PLL. Runs on the free-running 27 MHz board clock.
//  Drives the PLL RESET pin and qualifies the PLL lock output. Sequences the HyperRAM
//  controller reset and its calibration handshake, retrying on lock loss or timeout.
//  Sits between the HyperRAM PLL wrapper and the HyperRAM controller.
// PARAMETERS
//  PLL_RST_CYC        27      cycles pll_reset is held high per attempt
//  LOCK_TIMEOUT_CYC   27000   max cycles in WAIT_LOCK before a retry (1 ms)
//  LOCK_STABLE_CYC    2700    consecutive lock cycles needed before mem_rst release
//  CALIB_TIMEOUT_CYC  270000  max cycles in CALIB before a retry (10 ms)
//  MAX_RETRY          3       retries allowed before FAIL
//  SYNC_STAGES        2       synchronizer depth for pll_lock and calib_done (>=2)
//  CNT_W              20      width of the shared cycle counter; must hold every *_CYC
// PORTS
//  clk         in   1      27 MHz crystal clock
//  rst         in   1      synchronous reset, active-high
//  pll_lock    in   1      PLL LOCK, asynchronous
//  calib_done  in   1      controller init/calibration done, asynchronous, level
//  pll_reset   out  1      to PLL RESET, active-high
//  mem_rst     out  1      HyperRAM controller reset, active-high
//  ready       out  1      memory path usable
//  fail        out  1      retries exhausted; sticky until rst
// BEHAVIOUR
//  - All outputs are registered. lock_s and calib_s are synchronizer outputs.
//  - rst: state=PLL_RST, cnt=0, retry=0, pll_reset=1, mem_rst=1, ready=0, fail=0.
//  - PLL_RST: pll_reset=1 for exactly PLL_RST_CYC cycles, then go to WAIT_LOCK with cnt=0.
//  - WAIT_LOCK: if lock_s=1, go to STABLE with cnt=0. If cnt reaches LOCK_TIMEOUT_CYC-1, RETRY.
//  - STABLE: counts consecutive lock_s=1 cycles.
//    - lock_s=0: return to WAIT_LOCK with cnt=0. No retry is consumed.
//    - cnt reaches LOCK_STABLE_CYC-1: go to CALIB. mem_rst=0 from the first CALIB cycle.
//  - CALIB: go to READY on calib_s=1. lock_s=0 or cnt reaching CALIB_TIMEOUT_CYC-1 -> RETRY.
//    If calib_s and lock loss occur in the same cycle, lock loss wins.
//  - READY: ready=1 and retry=0. lock_s=0 -> RETRY. calib_s falling is ignored.
//  - RETRY is a transition, not a state; it completes in the same cycle.
//    - retry==MAX_RETRY: go to FAIL.
//    - Otherwise: retry++ and go to PLL_RST. mem_rst=1 and ready=0 on the next cycle.
//  - FAIL: pll_reset=0, mem_rst=1, ready=0, fail=1. Terminal until rst.
//  - mem_rst is 1 in every state except CALIB and READY. pll_reset is 1 only in PLL_RST.
//  - Latency: pll_lock held high from cycle t gives mem_rst falling at
//    t+SYNC_STAGES+LOCK_STABLE_CYC+1.
//  - cnt saturates and never wraps. Asserting rst mid-sequence restarts from PLL_RST.
// CONFIGURATION
//  HPRAM_SUP_STATUS_EN defined: adds two outputs.
//    - lock_loss_cnt (out, 8): counts READY->RETRY events; saturating at 255; cleared by rst only.
//    - state_dbg (out, 3): current state code.
//  HPRAM_SUP_STATUS_EN undefined: both ports and their logic are absent.
//    All other behaviour is identical.
// STRUCTURE
//  hpram_sup_pkg holds:
//    - state enum: PLL_RST=0, WAIT_LOCK=1, STABLE=2, CALIB=3, READY=4, FAIL=5;
//    - the default *_CYC constants;
//    - a function checking that CNT_W covers all *_CYC values.
//  Sub-module hpram_sync_bit (SYNC_STAGES flops, reset to 0), instantiated for
//  pll_lock and calib_done. One FSM and one shared counter live in the top level.
// TESTING (bench params: PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=128, LOCK_STABLE_CYC=16,
//  CALIB_TIMEOUT_CYC=64, MAX_RETRY=2, SYNC_STAGES=2)
//  - Nominal: rst, lock high at cycle 10, calib_done at cycle 50.
//    -> pll_reset high for cycles 0-3; mem_rst falls at cycle 29; ready rises within 3 cycles of 50.
//  - Glitch: lock high for 8 cycles, low for 3, then high.
//    -> STABLE restarts; retry stays 0; mem_rst falls 16+3 cycles after the second rise.
//  - Lock loss in READY: drop lock for 5 cycles.
//    -> ready=0 and mem_rst=1 within 3 cycles; pll_reset pulses for 4 cycles;
//       lock_loss_cnt=1 (STATUS_EN).
//  - Calibration timeout: calib_done never rises.
//    -> 3 CALIB attempts of 64 cycles each; then fail=1, mem_rst=1, pll_reset=0, held.
//  - Lock never arrives -> fail=1 after 3x(4+128) cycles.
//    Then pulse rst -> all outputs return to reset values next cycle.
//  - Simultaneous calib_done rise and lock drop in CALIB -> RETRY taken; ready stays 0.

Source files
------------

// File: rtl/hpram_sup_pkg.sv
// Shared types and defaults for the HyperRAM clock supervisor.
// Holds the FSM state encoding, default cycle counts and the counter-width check.
package hpram_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    CALIB     = 3'd3,
    READY     = 3'd4,
    FAIL      = 3'd5
  } sup_state_e;

  localparam int unsigned DEF_PLL_RST_CYC       = 27;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC  = 27000;
  localparam int unsigned DEF_LOCK_STABLE_CYC   = 2700;
  localparam int unsigned DEF_CALIB_TIMEOUT_CYC = 270000;
  localparam int unsigned DEF_CNT_W             = 20;

  // True when a cnt_w-bit counter can represent every cycle constant.
  function automatic bit cnt_w_covers(input int unsigned cnt_w,
                                      input int unsigned a,
                                      input int unsigned b,
                                      input int unsigned c,
                                      input int unsigned d);
    longint unsigned lim;
    lim = 64'd1 << cnt_w;
    return (64'(a) < lim) && (64'(b) < lim) && (64'(c) < lim) && (64'(d) < lim);
  endfunction

endpackage

// File: rtl/hpram_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
module hpram_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hpram_clk_supervisor.sv
// HyperRAM PLL reset / lock qualification and controller calibration sequencer.
// Optional status outputs (lock_loss_cnt, state_dbg) under `HPRAM_SUP_STATUS_EN.
module hpram_clk_supervisor
  import hpram_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC       = DEF_PLL_RST_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC  = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned LOCK_STABLE_CYC   = DEF_LOCK_STABLE_CYC,
  parameter int unsigned CALIB_TIMEOUT_CYC = DEF_CALIB_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY         = 3,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned CNT_W             = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       calib_done,
  output logic       pll_reset,
  output logic       mem_rst,
  output logic       ready,
  output logic       fail
`ifdef HPRAM_SUP_STATUS_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state_dbg
`endif
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CALIB_TO_LAST = CNT_W'(CALIB_TIMEOUT_CYC - 1);
  localparam int unsigned      RETRY_W       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  if (!cnt_w_covers(CNT_W, PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC,
                    CALIB_TIMEOUT_CYC)) begin : g_bad_cnt_w
    $fatal(1, "CNT_W too narrow for the configured cycle counts");
  end

  sup_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               cnt_clr, take_retry;
  logic               lock_s, calib_s;

  hpram_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  hpram_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_calib (
    .clk (clk),
    .rst (rst),
    .d   (calib_done),
    .q   (calib_s)
  );

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    cnt_clr    = 1'b0;
    take_retry = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_clr = 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_clr = 1'b1;
        end else if (cnt_q == LOCK_TO_LAST) begin
          take_retry = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_clr = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = CALIB;
          cnt_clr = 1'b1;
        end
      end
      CALIB: begin
        // Lock loss outranks a coincident calibration-done.
        if (!lock_s || cnt_q == CALIB_TO_LAST) begin
          take_retry = 1'b1;
        end else if (calib_s) begin
          state_d = READY;
          retry_d = '0;
          cnt_clr = 1'b1;
        end
      end
      READY: begin
        if (!lock_s) take_retry = 1'b1;
      end
      FAIL: ;
      default: begin
        state_d = PLL_RST;
        cnt_clr = 1'b1;
      end
    endcase

    if (take_retry) begin
      cnt_clr = 1'b1;
      if (retry_q == RETRY_MAX) begin
        state_d = FAIL;
      end else begin
        state_d = PLL_RST;
        retry_d = retry_q + RETRY_W'(1);
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_reset <= 1'b1;
      mem_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      if (cnt_clr)         cnt_q <= '0;
      else if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      pll_reset <= (state_d == PLL_RST);
      mem_rst   <= !((state_d == CALIB) || (state_d == READY));
      ready     <= (state_d == READY);
      fail      <= (state_d == FAIL);
    end
  end

`ifdef HPRAM_SUP_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_loss_cnt <= '0;
    end else if (state_q == READY && take_retry && lock_loss_cnt != '1) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_hpram_clk_supervisor.sv
// Self-checking bench for hpram_clk_supervisor: directed and randomized lock/calib
// timelines compared against event-time formulas derived from the sequencing rules.
module tb_hpram_clk_supervisor;

  localparam int P  = 4;
  localparam int LT = 128;
  localparam int LS = 16;
  localparam int CT = 64;
  localparam int MR = 2;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic rst, pll_lock, calib_done;
  logic pll_reset, mem_rst, ready, fail;
`ifdef HPRAM_SUP_STATUS_EN
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_dbg;
`endif

  int t, checks, errors;
  int n_prst, n_memlo, first_memlo, first_rdy, first_fail;

  always #5 clk = ~clk;

  hpram_clk_supervisor #(
    .PLL_RST_CYC       (P),
    .LOCK_TIMEOUT_CYC  (LT),
    .LOCK_STABLE_CYC   (LS),
    .CALIB_TIMEOUT_CYC (CT),
    .MAX_RETRY         (MR),
    .SYNC_STAGES       (S),
    .CNT_W             (20)
  ) dut (
`ifdef HPRAM_SUP_STATUS_EN
    .lock_loss_cnt (lock_loss_cnt),
    .state_dbg     (state_dbg),
`endif
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .calib_done (calib_done),
    .pll_reset  (pll_reset),
    .mem_rst    (mem_rst),
    .ready      (ready),
    .fail       (fail)
  );

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic sample();
    if (pll_reset === 1'b1) n_prst++;
    if (mem_rst === 1'b0) begin
      n_memlo++;
      if (first_memlo < 0) first_memlo = t;
    end
    if (ready === 1'b1 && first_rdy < 0) first_rdy = t;
    if (fail === 1'b1 && first_fail < 0) first_fail = t;
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
    t++;
    sample();
  endtask

  task automatic tick_to(input int c);
    while (t < c) tick1();
  endtask

  // Leaves the bench in cycle 0: the cycle right after the last edge that saw rst=1.
  task automatic do_reset();
    rst = 1'b1;
    pll_lock = 1'b0;
    calib_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    n_prst = 0;
    n_memlo = 0;
    first_memlo = -1;
    first_rdy = -1;
    first_fail = -1;
    sample();
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return pll_reset;
      1:       return mem_rst;
      2:       return ready;
      default: return fail;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int budget, input string tag);
    int n;
    n = 0;
    while (sig(which) !== val && n < budget) begin
      tick1();
      n++;
    end
    chk(tag, 32'(sig(which)), 32'(val));
  endtask

  initial begin
    int d, L, C, M, h, g, R;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pll_lock = 1'b0;
    calib_done = 1'b0;

    // Nominal bring-up
    do_reset();
    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_mem_rst",   32'(mem_rst),   1);
    chk("rst_ready",     32'(ready),     0);
    chk("rst_fail",      32'(fail),      0);
    tick_to(P - 1);
    chk("nom_prst_last", 32'(pll_reset), 1);
    tick_to(P);
    chk("nom_prst_end",  32'(pll_reset), 0);
    tick_to(10);
    pll_lock = 1'b1;
    tick_to(50);
    calib_done = 1'b1;
    wait_for(2, 1'b1, 40, "nom_ready_reached");
    chk("nom_memrst_fall", first_memlo, 10 + S + LS + 1);
    chk("nom_ready_at",    first_rdy,   50 + S + 1);

    // Lock loss while READY
    tick_to(60);
    d = 60;
    pll_lock = 1'b0;
    wait_for(2, 1'b0, 10, "ll_ready_drop");
    chk("ll_drop_at",  t, d + S + 1);
    chk("ll_mem_rst",  32'(mem_rst), 1);
    first_rdy = -1;
    tick_to(d + 5);
    pll_lock = 1'b1;
    tick_to(d + S + P);
    chk("ll_prst_hold", 32'(pll_reset), 1);
    tick1();
    chk("ll_prst_end",  32'(pll_reset), 0);
    wait_for(2, 1'b1, 80, "ll_ready_back");
    chk("ll_ready_back_at", first_rdy, imax(d + S + 1 + P, d + 5 + S) + 1 + LS + 1);
`ifdef HPRAM_SUP_STATUS_EN
    chk("ll_loss_cnt", 32'(lock_loss_cnt), 1);
`endif

    // Randomized lock / calibration arrival times
    for (int k = 0; k < 4; k++) begin
      L = int'($urandom_range(5, 40));
      C = int'($urandom_range(20, 80));
      do_reset();
      while (t < imax(L, C)) begin
        tick1();
        if (t == L) pll_lock = 1'b1;
        if (t == C) calib_done = 1'b1;
      end
      M = imax(P, L + S) + 1 + LS;
      wait_for(2, 1'b1, 200, "rnd_ready_reached");
      chk("rnd_memrst_fall", first_memlo, M);
      chk("rnd_ready_at",    first_rdy,   imax(C + S, M) + 1);
    end

    // Lock glitch during STABLE: first one fixed, the rest random
    for (int k = 0; k < 4; k++) begin
      do_reset();
      L = 10;
      if (k == 0) begin
        h = 8;
        g = 3;
      end else begin
        h = int'($urandom_range(1, 14));
        g = int'($urandom_range(1, 6));
      end
      R = L + h + g;
      while (t < R) begin
        tick1();
        if (t == L)     pll_lock = 1'b1;
        if (t == L + h) pll_lock = 1'b0;
        if (t == R)     pll_lock = 1'b1;
      end
      wait_for(1, 1'b0, 80, "gl_memrst_reached");
      chk("gl_memrst_fall", first_memlo, R + S + 1 + LS);
      chk("gl_no_retry",    n_prst, P);
    end

    // Calibration never completes
    do_reset();
    tick_to(10);
    pll_lock = 1'b1;
    wait_for(3, 1'b1, 400, "ct_fail_reached");
    chk("ct_fail_at",   first_fail, (10 + S + LS + 1) + CT + MR * (P + 1 + LS + CT));
    chk("ct_calib_cyc", n_memlo, (MR + 1) * CT);
    chk("ct_prst_cyc",  n_prst,  (MR + 1) * P);
    chk("ct_mem_rst",   32'(mem_rst),   1);
    chk("ct_pll_reset", 32'(pll_reset), 0);
    chk("ct_ready",     32'(ready),     0);
    tick_to(t + 20);
    chk("ct_fail_held",  32'(fail),      1);
    chk("ct_prst_held",  32'(pll_reset), 0);
    chk("ct_mrst_held",  32'(mem_rst),   1);

    // Coincident calib_done rise and lock drop in CALIB
    do_reset();
    tick_to(10);
    pll_lock = 1'b1;
    tick_to(40);
    calib_done = 1'b1;
    pll_lock = 1'b0;
    tick_to(60);
    chk("sim_never_ready", first_rdy, -1);
    chk("sim_retry_prst",  n_prst, 2 * P);
    chk("sim_calib_cyc",   n_memlo, (40 + S + 1) - (10 + S + LS + 1));

    // Lock never arrives, then reset from FAIL
    do_reset();
    wait_for(3, 1'b1, 500, "ln_fail_reached");
    chk("ln_fail_at",  first_fail, (MR + 1) * (P + LT));
    chk("ln_prst_cyc", n_prst, (MR + 1) * P);
    rst = 1'b1;
    tick1();
    chk("ln_rst_pll_reset", 32'(pll_reset), 1);
    chk("ln_rst_mem_rst",   32'(mem_rst),   1);
    chk("ln_rst_ready",     32'(ready),     0);
    chk("ln_rst_fail",      32'(fail),      0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
